// File: rtl/freq_gate_ctrl.sv
// Gate-time controller: clears an external counter, opens a gate of gate_len clk_in cycles,
// then latches the count and overflow flag. Optional re-arm via `define FREQ_GATE_CONT_MODE_EN.
module freq_gate_ctrl #(
  parameter int CNT_WIDTH  = 16,
  parameter int GATE_WIDTH = 24
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [GATE_WIDTH-1:0] gate_len,
  input  logic                  evt_in,
  input  logic [CNT_WIDTH-1:0]  cnt_in,
`ifdef FREQ_GATE_CONT_MODE_EN
  input  logic                  cont,
`endif
  output logic                  cnt_clr_n,
  output logic                  cnt_en,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  result,
  output logic                  result_valid,
  output logic                  result_ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLR   = 2'd1;
  localparam logic [1:0] S_GATE  = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  localparam logic [GATE_WIDTH-1:0] GATE_ONE = GATE_WIDTH'(1);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [GATE_WIDTH-1:0] gate_len_r;
  logic [GATE_WIDTH-1:0] gate_cnt;
  logic [GATE_WIDTH-1:0] gate_len_eff;
  logic                  ovf_flag;
  logic                  rearm;
  logic                  capture;

`ifdef FREQ_GATE_CONT_MODE_EN
  assign rearm = cont;
`else
  assign rearm = 1'b0;
`endif

  // A zero-length gate would never terminate the down-counter, so it runs as one cycle.
  assign gate_len_eff = (gate_len == '0) ? GATE_ONE : gate_len;

  assign capture = ((state == S_IDLE)  && start && !abort) ||
                   ((state == S_LATCH) && rearm && !abort);

  assign cnt_en    = evt_in && (state == S_GATE);
  assign cnt_clr_n = (state != S_CLR);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start && !abort) state_nxt = S_CLR;
      end
      S_CLR: begin
        state_nxt = abort ? S_IDLE : S_GATE;
      end
      S_GATE: begin
        if (abort)                 state_nxt = S_IDLE;
        else if (gate_cnt == '0)   state_nxt = S_LATCH;
      end
      S_LATCH: begin
        if (abort)      state_nxt = S_IDLE;
        else if (rearm) state_nxt = S_CLR;
        else            state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      gate_len_r   <= '0;
      gate_cnt     <= '0;
      ovf_flag     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      result_ovf   <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != S_IDLE);
      result_valid <= 1'b0;

      if (capture) gate_len_r <= gate_len_eff;

      case (state)
        S_CLR: begin
          gate_cnt <= gate_len_r - GATE_ONE;
          ovf_flag <= 1'b0;
        end
        S_GATE: begin
          if (gate_cnt != '0) gate_cnt <= gate_cnt - GATE_ONE;
          // Seeing all-ones while enabled means the counter wraps on this edge.
          if (cnt_en && (cnt_in == '1)) ovf_flag <= 1'b1;
        end
        S_LATCH: begin
          if (!abort) begin
            result       <= cnt_in;
            result_ovf   <= ovf_flag;
            result_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
Gate-time controller that sequences an external counter_n_bit instance for event counting and frequency measurement in the DSO acquisition path.
- On start: clears the counter, opens a gate of a programmed number of clk_in cycles, qualifies the counter enable with the event input, then latches the count and flags overflow.
- Single-shot by default; optional continuous re-arm.

Parameters:
CNT_WIDTH, 16, width of the external counter value and of result
GATE_WIDTH, 24, width of the gate-length configuration

Ports:
clk_in  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset, 1 = run)
start  in  1  request a measurement; sampled only in IDLE
abort  in  1  cancel measurement in progress; synchronous
gate_len  in  GATE_WIDTH  gate length in clk_in cycles; captured on start
evt_in  in  1  event qualifier, synchronous to clk_in; counted once per cycle high inside gate
cnt_in  in  CNT_WIDTH  current value from external counter
cnt_clr_n  out  1  counter synchronous clear (drives counter rst); 0 = clear
cnt_en  out  1  counter enable
busy  out  1  measurement in progress
result  out  CNT_WIDTH  latched count of last completed measurement
result_valid  out  1  one-cycle pulse: result/result_ovf updated
result_ovf  out  1  counter reached all-ones inside last gate (possible wrap)

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - result=0, result_valid=0, result_ovf=0, busy=0.
  - cnt_en=0, cnt_clr_n=1.
  - Internal gate counter and ovf flag are 0.
- States:
  - IDLE: busy=0. start=1 and abort=0 → capture gate_len into gate_len_r (gate_len=0 treated as 1) → CLR.
  - CLR: one cycle, cnt_clr_n=0, cnt_en=0; load gate_cnt=gate_len_r-1 → GATE.
  - GATE: cnt_en=evt_in (combinational AND with state); decrement gate_cnt each cycle; gate_cnt==0 → LATCH.
    - Exactly gate_len_r cycles are spent in GATE.
  - LATCH: one cycle, cnt_en=0; result<=cnt_in, result_ovf<=ovf_flag, result_valid<=1 → IDLE.
- cnt_clr_n = 0 only in CLR. busy = 1 in CLR, GATE and LATCH.
- Timing, with start sampled at edge 0 and N = gate_len:
  - CLR occupies cycle 1.
  - GATE occupies cycles 2..N+1.
  - LATCH occupies cycle N+2; the counter's final value is stable here.
  - result_valid is high in cycle N+3 only, with result valid from the same cycle.
  - Back-to-back start is accepted in cycle N+3.
- Overflow: in GATE, if cnt_en=1 and cnt_in == all-ones, set ovf_flag (sticky until next CLR).
  - result holds the wrapped counter value unchanged.
- abort=1 in CLR/GATE/LATCH:
  - Next state is IDLE; cnt_en=0 from the next cycle.
  - No result_valid pulse; result and result_ovf hold their previous values.
  - abort outranks LATCH completion in the same cycle.
- abort and start together in IDLE: stay IDLE.
- start while busy: ignored, no queuing.
- gate_len changes after capture have no effect until the next start.
- result_valid is a registered pulse; all other outputs except cnt_en/cnt_clr_n are registered.
- cnt_en and cnt_clr_n are decoded from the registered state.

Optional Feature:
FREQ_GATE_CONT_MODE_EN.
- Defined: adds input port cont (1 bit).
  - In LATCH with cont=1 and abort=0: result is still latched and result_valid still pulses, but next state is CLR, not IDLE.
  - gate_len is recaptured at that transition; busy stays high.
  - Period between result_valid pulses is N+2 cycles.
  - cont=0 or abort returns to single-shot behaviour.
- Undefined: no cont port; every measurement ends in IDLE.

Test Plan:
- Reset mid-GATE (rst low asynchronously):
  → outputs immediately at reset values, state IDLE.
  → after release, start works normally.
- gate_len=10, evt_in=1 constantly, start pulse at edge 0:
  → cnt_clr_n low in cycle 1; cnt_en high cycles 2..11.
  → result_valid in cycle 13 only, result=10, result_ovf=0.
- gate_len=100, evt_in toggling every cycle starting high:
  → result=50; start asserted during busy is ignored; second start in cycle 103 yields result=50 again.
- CNT_WIDTH=4, gate_len=20, evt_in=1:
  → result=4 (20 mod 16), result_ovf=1.
  → next run with gate_len=5 gives result=5, result_ovf=0.
- gate_len=0:
  → behaves as 1, result=1 with evt_in=1.
- abort in cycle 5 of gate_len=10 run:
  → no result_valid, result unchanged from previous, busy=0 next cycle.
- abort and start together in IDLE:
  → no measurement starts.
- With FREQ_GATE_CONT_MODE_EN, cont=1, gate_len=8, evt_in=1:
  → result_valid pulses every 10 cycles, result=8 each time.
  → dropping cont ends after the current measurement.
